// File: rtl/mem_responder.sv
// Purpose: single-port-style instruction/data memory responder with zero-fill init and a 1-entry store buffer.
// Latency: fetch and read return one cycle after the sampling edge; writes commit to the array one edge later.
// Backpressure: none; accepts a fetch, a read and a write every cycle, ready stays low during init.
module mem_responder #(
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  output logic [31:0] instruction,
  input  logic        read,
  input  logic [31:0] read_address,
  output logic [31:0] DATA_in,
  input  logic        write,
  input  logic [31:0] write_address,
  input  logic [31:0] DATA_out,
  input  logic [1:0]  size,
  output logic        ready,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt;
  logic [31:0]   mem [DEPTH];

  // store buffer: one pending write, data already placed in its byte lanes
  logic          sb_vld;
  logic [AW-1:0] sb_idx;
  logic [31:0]   sb_dat;
  logic [3:0]    sb_mask;

  logic [AW-1:0] fetch_idx, rd_idx, wr_idx;
  logic [31:0]   fetch_word, rd_word, rd_ext;
  logic [31:0]   wr_dat;
  logic [3:0]    wr_mask;
  logic          running, f_fetch, f_rd, f_wr, any_fault;

  // out-of-range, reserved size and misalignment all count as faults
  function automatic logic acc_fault(input logic [31:0] addr, input logic [1:0] sz);
    logic oor;
    oor = |(addr >> (AW + 2));
    case (sz)
      2'b00:   acc_fault = oor;
      2'b01:   acc_fault = oor | addr[0];
      2'b10:   acc_fault = oor | (addr[1:0] != 2'b00);
      default: acc_fault = 1'b1;
    endcase
  endfunction

  assign running   = (state == S_RUN);
  assign ready     = running;
  assign fetch_idx = i_address[AW+1:2];
  assign rd_idx    = read_address[AW+1:2];
  assign wr_idx    = write_address[AW+1:2];
  assign f_fetch   = acc_fault(i_address, 2'b10);
  assign f_rd      = read  & acc_fault(read_address, size);
  assign f_wr      = write & acc_fault(write_address, size);
  assign any_fault = running & (f_fetch | f_rd | f_wr);

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_INIT;
    else        state <= state_nxt;
  end

  // leave INIT once the last word has been cleared
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (cnt == AW'(DEPTH - 1)) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  // init word counter
  always_ff @(posedge clk) begin
    if (!reset)             cnt <= '0;
    else if (state == S_INIT) cnt <= cnt + 1'b1;
  end

  // array reads with byte-wise forwarding of the pending buffered write
  always_comb begin
    fetch_word = mem[fetch_idx];
    rd_word    = mem[rd_idx];
    for (int b = 0; b < 4; b++) begin
      if (sb_vld && sb_mask[b]) begin
        if (sb_idx == fetch_idx) fetch_word[8*b +: 8] = sb_dat[8*b +: 8];
        if (sb_idx == rd_idx)    rd_word[8*b +: 8]    = sb_dat[8*b +: 8];
      end
    end
  end

  // right-align and zero-extend the read lane
  always_comb begin
    rd_ext = rd_word;
    case (size)
      2'b00:   rd_ext = {24'h0, rd_word[{read_address[1:0], 3'b000} +: 8]};
      2'b01:   rd_ext = {16'h0, rd_word[{read_address[1], 4'b0000} +: 16]};
      default: rd_ext = rd_word;
    endcase
  end

  // replicate write data into every lane and pick lanes with the mask
  always_comb begin
    wr_dat  = DATA_out;
    wr_mask = 4'b1111;
    case (size)
      2'b00: begin
        wr_dat  = {4{DATA_out[7:0]}};
        wr_mask = 4'b0001 << write_address[1:0];
      end
      2'b01: begin
        wr_dat  = {2{DATA_out[15:0]}};
        wr_mask = write_address[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wr_dat  = DATA_out;
        wr_mask = 4'b1111;
      end
    endcase
  end

  // store buffer: load accepted writes, otherwise drain after commit
  always_ff @(posedge clk) begin
    if (!reset) begin
      sb_vld  <= 1'b0;
      sb_idx  <= '0;
      sb_dat  <= '0;
      sb_mask <= '0;
    end else if (running && write && !f_wr) begin
      sb_vld  <= 1'b1;
      sb_idx  <= wr_idx;
      sb_dat  <= wr_dat;
      sb_mask <= wr_mask;
    end else begin
      sb_vld  <= 1'b0;
    end
  end

  // array write port: zero-fill during INIT, buffered commit during RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == S_INIT) begin
        mem[cnt] <= '0;
      end else if (sb_vld) begin
        for (int b = 0; b < 4; b++)
          if (sb_mask[b]) mem[sb_idx][8*b +: 8] <= sb_dat[8*b +: 8];
      end
    end
  end

  // registered responses and fault reporting
  always_ff @(posedge clk) begin
    if (!reset) begin
      instruction <= NOP_WORD;
      DATA_in     <= '0;
      err         <= 1'b0;
      err_count   <= '0;
    end else if (!running) begin
      instruction <= NOP_WORD;
      DATA_in     <= '0;
      err         <= 1'b0;
    end else begin
      instruction <= f_fetch ? NOP_WORD : fetch_word;
      if (read) DATA_in <= f_rd ? 32'h0 : rd_ext;
      err <= any_fault;
      if (any_fault && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Purpose: self-checking bench for mem_responder using directed vectors and a byte-level reference memory.
// Latency: checks every output one cycle after the edge that sampled the request.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_mem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_address, read_address, write_address, DATA_out;
  logic        read, write;
  logic [1:0]  size;
  logic [31:0] instruction, DATA_in;
  logic        ready, err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  // reference: architectural byte memory, writes visible from the next cycle
  logic [7:0]  mm [4096];
  int          m_ec;
  logic [31:0] m_data;

  mem_responder #(.DEPTH(1024), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .i_address(i_address), .instruction(instruction),
    .read(read), .read_address(read_address), .DATA_in(DATA_in),
    .write(write), .write_address(write_address), .DATA_out(DATA_out),
    .size(size), .ready(ready), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] ra;
    logic        wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic [31:0] ia;
    logic [31:0] e_data;
    logic [31:0] e_instr;
    logic        e_err;
    logic [7:0]  e_ec;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic bit m_fault(input logic [31:0] a, input logic [1:0] s);
    if (a >= 32'h1000) return 1'b1;
    if (s == 2'd3) return 1'b1;
    if ((a % (32'd1 << s)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < (1 << s); i++)
      v = v | (32'(mm[12'(a + 32'(i))]) << (8 * i));
    return v;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
    m_ec   = 0;
    m_data = '0;
  endtask

  task automatic set_req(input logic rd, input logic [31:0] ra, input logic wr, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [1:0] sz, input logic [31:0] ia);
    read = rd; read_address = ra; write = wr; write_address = wa;
    DATA_out = wd; size = sz; i_address = ia;
  endtask

  // one RUN-mode cycle: predict, clock, compare, then retire the write into the model
  task automatic tick();
    bit ef, er, ew, anyf;
    logic [31:0] ei;
    ef   = m_fault(i_address, 2'd2);
    er   = read && m_fault(read_address, size);
    ew   = write && m_fault(write_address, size);
    anyf = ef | er | ew;
    ei   = ef ? NOP : m_load(i_address, 2'd2);
    if (read) m_data = er ? 32'h0 : m_load(read_address, size);
    if (anyf && m_ec < 255) m_ec++;
    @(posedge clk); #1;
    check("instruction", instruction, ei);
    check("data_in", DATA_in, m_data);
    check("err", {31'b0, err}, {31'b0, anyf});
    check("err_count", 32'(err_count), 32'(m_ec));
    check("ready", {31'b0, ready}, 32'd1);
    if (write && !ew)
      for (int i = 0; i < (1 << size); i++)
        mm[12'(write_address + 32'(i))] = 8'(DATA_out >> (8 * i));
  endtask

  // count cycles from reset release to ready; INIT must answer NOP/0 and never fault
  task automatic wait_ready(input string nm);
    int n;
    bit quiet;
    n = 0;
    quiet = 1'b1;
    while (n < 3000) begin
      set_req(1'($urandom_range(0, 1)), $urandom_range(0, 32'h1FFF), 1'($urandom_range(0, 1)),
              $urandom_range(0, 32'h1FFF), $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 32'h1FFF));
      @(posedge clk); #1;
      n++;
      if (instruction !== NOP || DATA_in !== 32'h0 || err !== 1'b0) quiet = 1'b0;
      if (ready === 1'b1) break;
    end
    check(nm, 32'(n), 32'd1024);
    check("init_quiet", {31'b0, quiet}, 32'd1);
    set_req(0, 0, 0, 0, 0, 2'd2, 0);
  endtask

  initial begin
    // rd ra wr wa wd sz ia | data instr err ec
    tbl[0]  = '{1'b0, 32'h00, 1'b1, 32'h13, 32'h123456AA, 2'd0, 32'h0, 32'h00000000, 32'h0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 32'h12, 1'b0, 32'h00, 32'h0,        2'd1, 32'h0, 32'h0000AA00, 32'h0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 32'h13, 1'b0, 32'h00, 32'h0,        2'd0, 32'h0, 32'h000000AA, 32'h0, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 32'h00, 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 32'h0, 32'h000000AA, 32'h0, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 32'h10, 1'b0, 32'h00, 32'h0,        2'd2, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 32'h00, 1'b1, 32'h20, 32'h11111111, 2'd2, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 32'h00, 1'b0, 32'h00, 32'h0,        2'd2, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 32'h20, 1'b1, 32'h20, 32'h22222222, 2'd2, 32'h0, 32'h11111111, 32'h0, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 32'h20, 1'b0, 32'h00, 32'h0,        2'd2, 32'h0, 32'h22222222, 32'h0, 1'b0, 8'd0};
    tbl[9]  = '{1'b1, 32'h06, 1'b0, 32'h00, 32'h0,        2'd2, 32'h0, 32'h00000000, 32'h0, 1'b1, 8'd1};
    tbl[10] = '{1'b0, 32'h00, 1'b0, 32'h00, 32'h0,        2'd2, 32'h0, 32'h00000000, 32'h0, 1'b0, 8'd1};
    tbl[11] = '{1'b0, 32'h00, 1'b1, 32'h40, 32'hA5A5A5A5, 2'd2, 32'h0, 32'h00000000, 32'h0, 1'b0, 8'd1};
    tbl[12] = '{1'b0, 32'h00, 1'b1, 32'h42, 32'h0000BEEF, 2'd1, 32'h0, 32'h00000000, 32'h0, 1'b0, 8'd1};
    tbl[13] = '{1'b1, 32'h40, 1'b1, 32'h40, 32'h12345678, 2'd2, 32'h0, 32'hBEEFA5A5, 32'h0, 1'b0, 8'd1};
    tbl[14] = '{1'b1, 32'h40, 1'b0, 32'h00, 32'h0,        2'd2, 32'h0, 32'h12345678, 32'h0, 1'b0, 8'd1};
    tbl[15] = '{1'b0, 32'h00, 1'b0, 32'h00, 32'h0,        2'd2, 32'h40, 32'h12345678, 32'h12345678, 1'b0, 8'd1};
    tbl[16] = '{1'b0, 32'h00, 1'b0, 32'h00, 32'h0,        2'd2, 32'h2, 32'h12345678, NOP, 1'b1, 8'd2};
    tbl[17] = '{1'b1, 32'h00, 1'b1, 32'h01, 32'h0,        2'd3, 32'h4000, 32'h00000000, NOP, 1'b1, 8'd3};
    tbl[18] = '{1'b0, 32'h00, 1'b1, 32'h1040, 32'hFFFFFFFF, 2'd2, 32'h0, 32'h00000000, 32'h0, 1'b1, 8'd4};
    tbl[19] = '{1'b1, 32'h40, 1'b0, 32'h00, 32'h0,        2'd2, 32'h0, 32'h12345678, 32'h0, 1'b0, 8'd4};
    tbl[20] = '{1'b0, 32'h00, 1'b1, 32'h80, 32'hCAFEF00D, 2'd2, 32'h0, 32'h12345678, 32'h0, 1'b0, 8'd4};
    tbl[21] = '{1'b0, 32'h00, 1'b0, 32'h00, 32'h0,        2'd2, 32'h80, 32'h12345678, 32'hCAFEF00D, 1'b0, 8'd4};

    // reset state
    reset = 1'b0;
    set_req(0, 0, 0, 0, 0, 2'd2, 0);
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_instruction", instruction, NOP);
    check("rst_data_in", DATA_in, 32'h0);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);

    // init sequence length after release
    reset = 1'b1;
    wait_ready("init_cycles");

    // directed vectors
    for (int k = 0; k < 22; k++) begin
      set_req(tbl[k].rd, tbl[k].ra, tbl[k].wr, tbl[k].wa, tbl[k].wd, tbl[k].sz, tbl[k].ia);
      tick();
      check($sformatf("vec%0d_data", k), DATA_in, tbl[k].e_data);
      check($sformatf("vec%0d_instr", k), instruction, tbl[k].e_instr);
      check($sformatf("vec%0d_err", k), {31'b0, err}, {31'b0, tbl[k].e_err});
      check($sformatf("vec%0d_ec", k), 32'(err_count), 32'(tbl[k].e_ec));
    end

    // randomized traffic in a small window so reads hit recent writes
    for (int k = 0; k < 2000; k++) begin
      logic [1:0]  sz;
      logic [31:0] ra, wa, ia;
      int r;
      r  = $urandom_range(0, 15);
      sz = (r == 0) ? 2'd3 : 2'(r % 3);
      ra = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 32'h1FFF) : $urandom_range(0, 255);
      wa = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 32'h1FFF) : $urandom_range(0, 255);
      ia = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 32'h1FFF) : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 1) == 1) begin
        ra = ra & ~32'h3;
        wa = wa & ~32'h3;
      end
      set_req(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, $urandom, sz, ia);
      tick();
    end

    // counter saturation under a long run of faults
    for (int k = 0; k < 300; k++) begin
      set_req(1, 32'h6, 0, 0, 0, 2'd2, 0);
      tick();
    end
    check("err_count_sat", 32'(err_count), 32'd255);
    set_req(0, 0, 0, 0, 0, 2'd2, 0);
    tick();
    check("err_after_sat", {31'b0, err}, 32'd0);

    // reset with a write still buffered, then reset again in the middle of INIT
    set_req(0, 0, 1, 32'h40, 32'h99999999, 2'd2, 0);
    tick();
    reset = 1'b0;
    set_req(0, 0, 0, 0, 0, 2'd2, 0);
    @(posedge clk); #1;
    check("rst2_ready", {31'b0, ready}, 32'd0);
    check("rst2_err_count", 32'(err_count), 32'd0);
    reset = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    check("mid_init_ready", {31'b0, ready}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_ready", {31'b0, ready}, 32'd0);
    check("mid_rst_instr", instruction, NOP);
    reset = 1'b1;
    m_clear();
    wait_ready("reinit_cycles");

    // array contents were cleared and the discarded write never landed
    set_req(1, 32'h40, 0, 0, 0, 2'd2, 32'h10);
    tick();
    check("post_init_read", DATA_in, 32'h0);
    set_req(1, 32'h10, 0, 0, 0, 2'd2, 32'h40);
    tick();
    check("post_init_fetch", instruction, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words of storage (power of two, at least 4).
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013, meaning the instruction returned while not ready or on a fetch fault.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port i_address, input, 32 bits: instruction fetch byte address.
REQ-006 SHALL have port instruction, output, 32 bits: fetched word, registered.
REQ-007 SHALL have port read, input, 1 bit: data read request.
REQ-008 SHALL have port read_address, input, 32 bits: data read byte address.
REQ-009 SHALL have port DATA_in, output, 32 bits: read data returned to the core, registered.
REQ-010 SHALL have port write, input, 1 bit: data write request.
REQ-011 SHALL have port write_address, input, 32 bits: data write byte address.
REQ-012 SHALL have port DATA_out, input, 32 bits: write data from the core, right-aligned.
REQ-013 SHALL have port size, input, 2 bits: access size (00 byte, 01 half, 10 word, 11 reserved), shared by read and write.
REQ-014 SHALL have port ready, output, 1 bit: high once initialisation is complete.
REQ-015 SHALL have port err, output, 1 bit: one-cycle fault pulse.
REQ-016 SHALL have port err_count, output, 8 bits: saturating fault counter.

Function
REQ-017 SHALL implement FSM INIT->RUN: entered in INIT after reset; writes zero to word cnt, cnt 0..DEPTH-1, one per cycle; moves to RUN after word DEPTH-1; ready=1 only in RUN.
REQ-018 SHALL, in INIT, return NOP_WORD on instruction and 0 on DATA_in, ignore writes, and raise no err.
REQ-019 SHALL form the word index from addr[log2(DEPTH)+1:2]; any address >= 4*DEPTH is out-of-range.
REQ-020 SHALL return the fetch for i_address sampled at edge T on instruction after edge T (1-cycle latency); a misaligned (bits[1:0]!=0) or out-of-range fetch returns NOP_WORD and faults.
REQ-021 SHALL, for a read at edge T, present on DATA_in after T the addressed byte/half/word right-aligned and zero-extended; DATA_in holds its value when read=0.
REQ-022 SHALL treat as faults: a read with size=11, a misaligned half (addr[0]=1), a misaligned word (addr[1:0]!=0), or out-of-range; a faulted read returns DATA_in=0.
REQ-023 SHALL post each accepted write at edge T into a 1-entry store buffer (word index, 32-bit merged data, 4-bit byte mask); the array is updated at edge T+1.
REQ-024 SHALL apply the REQ-022 fault rules to writes; a faulted write is dropped, leaving the buffer and array unchanged.
REQ-025 SHALL forward the buffered bytes, per byte mask, to both a fetch and a read of the buffered word, so a read at T+1 after a write at T sees the new data.
REQ-026 SHALL give a read and write to the same word in the same cycle the pre-write data (the current write is not visible).
REQ-027 SHALL allow back-to-back writes every cycle with no stall; a new write overwrites the buffer entry as the old entry commits.
REQ-028 SHALL pulse err high for one cycle after the edge that sampled any faulting request; when several faults occur in one cycle, err is a single pulse and err_count increments by 1.
REQ-029 SHALL saturate err_count at 255.

Reset
REQ-030 SHALL set, while reset=0 at an edge: instruction=NOP_WORD, DATA_in=0, ready=0, err=0, err_count=0, buffer invalid, state INIT, cnt=0.
REQ-031 SHALL, on reset asserted mid-INIT or in RUN, discard any pending buffered write and restart INIT at word 0.

Verification
REQ-032 SHALL cover: release reset, DEPTH=1024 -> ready rises exactly 1024 cycles later; every fetch before that returns 32'h00000013.
REQ-033 SHALL cover: write word 0xDEADBEEF at 0x10 (T), read word 0x10 (T+1) -> DATA_in=0xDEADBEEF after T+1 (forwarding).
REQ-034 SHALL cover: write byte 0xAA at 0x13, then read half 0x12 -> 0x0000AA00; read byte 0x13 -> 0x000000AA.
REQ-035 SHALL cover: read word at 0x6 -> DATA_in=0, err pulses 1 cycle, err_count=1; 300 faults -> err_count=255.
REQ-036 SHALL cover: same-cycle read/write 0x20 (old 0x11111111, new 0x22222222) -> read returns 0x11111111; the next read returns 0x22222222.
REQ-037 SHALL cover: reset pulsed at INIT cnt=500 -> ready=0; INIT restarts; ready rises 1024 cycles after release.
